// File: rtl/pwm_slew_pkg.sv
// Shared definitions for the PWM duty slew limiter.
//   PWM_DUTY_W    : default width of target / duty / step
//   PWM_DIV_W     : default width of the prescaler divisor
//   slew_state_t  : ramp state (IDLE / UP / DOWN)
//   slew_state_of : maps a duty-vs-target comparison onto a ramp state
package pwm_slew_pkg;

    localparam int unsigned PWM_DUTY_W = 8;
    localparam int unsigned PWM_DIV_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } slew_state_t;

    // Duty below target ramps up, above ramps down, equal is idle.
    function automatic slew_state_t slew_state_of(input logic duty_lt, input logic duty_gt);
        slew_state_t st;
        st = ST_IDLE;
        if (duty_lt) begin
            st = ST_UP;
        end else if (duty_gt) begin
            st = ST_DOWN;
        end
        return st;
    endfunction

endpackage

// File: rtl/pwm_slew_prescaler.sv
// Tick generator for the duty slew limiter.
// Counts enabled cycles and fires once every div+1 of them. A divisor
// lowered below the running count lets the counter wrap naturally through
// its full range before the next match.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_en       : count enable; 0 holds the counter at zero
//   i_div      : tick period minus one
//   o_tick_c   : combinational tick (en && cnt == div)
module pwm_slew_prescaler
    import pwm_slew_pkg::*;
#(
    parameter int unsigned DIV_W = PWM_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick_c
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick   = i_en && (r_cnt == i_div);
    assign o_tick_c = w_tick;

    // Counter: cleared when disabled or on tick, otherwise free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_slew.sv
// Slew-rate limiter between the SPI duty register and the PWM generator.
// Moves the applied duty toward the requested target by at most `step`
// per prescaler tick, so loads see ramps instead of jumps. step == 0
// bypasses the limiter (duty follows target on the next edge).
// Optional feature macro: PWM_SLEW_DONE_PULSE_EN adds the done_pulse port,
// a one-cycle strobe when a ramp (UP/DOWN) settles into IDLE.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : 1 = slewing active; 0 = freeze duty and prescaler
//   target     : requested duty (SPI register 0x04)
//   step       : max duty change per tick, 0 = bypass
//   div        : tick every div+1 enabled cycles
//   duty_q     : applied duty to the PWM generator (registered)
//   busy       : ramp in progress (registered)
//   done_pulse : ramp-complete strobe (only with PWM_SLEW_DONE_PULSE_EN)
module pwm_duty_slew
    import pwm_slew_pkg::*;
#(
    parameter int unsigned DUTY_W = PWM_DUTY_W,
    parameter int unsigned DIV_W  = PWM_DIV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DUTY_W-1:0] target,
    input  logic [DUTY_W-1:0] step,
    input  logic [DIV_W-1:0]  div,
    output logic [DUTY_W-1:0] duty_q,
    output logic              busy
`ifdef PWM_SLEW_DONE_PULSE_EN
    ,
    output logic              done_pulse
`endif
);

    slew_state_t       r_state;
    slew_state_t       w_state_nxt;
    slew_state_t       w_dir;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              w_tick;
    logic [DUTY_W:0]   w_up_diff;
    logic [DUTY_W:0]   w_dn_diff;
    logic [DUTY_W:0]   w_step_ext;

    pwm_slew_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (en),
        .i_div    (div),
        .o_tick_c (w_tick)
    );

    // Distances to target, one bit wider so neither side can wrap.
    always_comb begin
        w_step_ext = {1'b0, step};
        w_up_diff  = {1'b0, target} - {1'b0, r_duty};
        w_dn_diff  = {1'b0, r_duty} - {1'b0, target};
        // Direction follows the target present on this edge, so a
        // mid-ramp reversal takes effect immediately.
        w_dir      = slew_state_of(r_duty < target, r_duty > target);
    end

    // Next duty, state and busy.
    always_comb begin
        w_duty_nxt  = r_duty;
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        if (en) begin
            if (step == '0) begin
                w_duty_nxt = target;
            end else if (w_tick) begin
                case (w_dir)
                    ST_UP: begin
                        w_duty_nxt = (w_up_diff <= w_step_ext) ? target : (r_duty + step);
                    end
                    ST_DOWN: begin
                        w_duty_nxt = (w_dn_diff <= w_step_ext) ? target : (r_duty - step);
                    end
                    default: begin
                        w_duty_nxt = r_duty;
                    end
                endcase
            end
            w_state_nxt = slew_state_of(w_duty_nxt < target, w_duty_nxt > target);
            w_busy_nxt  = (w_state_nxt != ST_IDLE);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_duty  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign duty_q = r_duty;
    assign busy   = r_busy;

`ifdef PWM_SLEW_DONE_PULSE_EN
    logic r_done;
    logic w_done_nxt;

    // Strobe on the edge where an active ramp settles; idle bypass never fires.
    always_comb begin
        w_done_nxt = en && (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
        end
    end

    assign done_pulse = r_done;
`endif

endmodule
